store_write_buffer: RTL and testbench

- Posted-store FIFO between the pipeline's MEM stage and the single-port data memory.
- Stores retire into the buffer in one cycle and drain to memory in order over a valid/ready handshake, so memory latency does not stall the pipeline.
- Loads check the buffer combinationally. The youngest matching pending store is forwarded, so loads never read stale memory.
- A flush request drains the buffer completely and signals completion, for use at sync points and reset hand-off.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_match.sv | 42 ++++
 rtl/store_write_buffer.sv | 139 +++++++++++++
 tb/tb_store_write_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the store write buffer.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wb_match.sv
// Youngest-first word-address matcher over the buffer ring.
module wb_match
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned ADDR_W = WB_ADDR_W,
  localparam int unsigned PW     = ptr_w(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [PW-1:0]                wr_ptr_i,
  input  logic [ADDR_W-1:0]            lookup_i,
  output logic                         hit_o,
  output logic [PW-1:0]                idx_o
);

  logic [PW-1:0] cand;
  logic          unused_lo_bits;

  // Walk oldest to youngest so the last match written (closest to wr_ptr-1) wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      cand = wr_ptr_i - PW'(k);
      if (valid_i[cand] && (addr_i[cand][ADDR_W-1:2] == lookup_i[ADDR_W-1:2])) begin
        hit_o = 1'b1;
        idx_o = cand;
      end
    end
  end

  // Byte offsets take no part in the word compare.
  always_comb begin
    unused_lo_bits = ^lookup_i[1:0];
    for (int k = 0; k < int'(DEPTH); k++) begin
      unused_lo_bits = unused_lo_bits ^ (^addr_i[k][1:0]);
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store FIFO with load forwarding and flush drain.
// Optional in-place store coalescing when WB_COALESCE_EN is defined.
module store_write_buffer
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned ADDR_W = WB_ADDR_W,
  parameter  int unsigned DATA_W = WB_DATA_W,
  localparam int unsigned PW     = ptr_w(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              full,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [CW-1:0]     count
);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  wb_state_e                    state_q, state_d;

  logic          enq_c, deq_c, coal_c;
  logic [PW-1:0] ld_idx, co_idx;

  assign full       = (count_q == CW'(DEPTH)) || (state_q == ST_FLUSH);
  assign mem_valid  = (count_q != '0);
  assign mem_addr   = addr_q[rd_ptr_q];
  assign mem_data   = data_q[rd_ptr_q];
  assign flush_done = (state_q == ST_DONE);
  assign count      = count_q;

  wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ld_match (
    .addr_i   (addr_q),
    .valid_i  (valid_q),
    .wr_ptr_i (wr_ptr_q),
    .lookup_i (ld_addr),
    .hit_o    (ld_hit),
    .idx_o    (ld_idx)
  );

  assign ld_data = ld_hit ? data_q[ld_idx] : '0;

`ifdef WB_COALESCE_EN
  logic             co_hit;
  logic [DEPTH-1:0] head_mask;

  // The head may be mid-handshake, so it is excluded from coalescing.
  assign head_mask = DEPTH'(1) << rd_ptr_q;

  wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_co_match (
    .addr_i   (addr_q),
    .valid_i  (valid_q & ~head_mask),
    .wr_ptr_i (wr_ptr_q),
    .lookup_i (st_addr),
    .hit_o    (co_hit),
    .idx_o    (co_idx)
  );

  assign coal_c = st_valid && (state_q != ST_FLUSH) && co_hit;
`else
  assign coal_c = 1'b0;
  assign co_idx = '0;
`endif

  assign enq_c = st_valid && !full && !coal_c;
  assign deq_c = mem_valid && mem_ready;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;

    if (deq_c) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (enq_c) begin
      addr_d[wr_ptr_q]  = st_addr;
      data_d[wr_ptr_q]  = st_data;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (coal_c) begin
      data_d[co_idx] = st_data;
    end

    count_d = count_q + CW'(enq_c) - CW'(deq_c);

    // Flush sequencing; DONE lasts one cycle and ignores flush_req.
    case (state_q)
      ST_RUN:   if (flush_req) state_d = ST_FLUSH;
      ST_FLUSH: if (count_d == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_RUN;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Payload storage needs no reset; valid bits and count gate its use.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: queue-based reference model, decoupled memory-side monitor.
module tb_store_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          st_valid = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic          full;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ready = 1'b0;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic [CW-1:0] count;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .full       (full),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .ld_data    (ld_data),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .count      (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Model: pending stores oldest-first; q[0] is what memory must see next.
  ent_t q[$];
  bit   in_flush = 1'b0;
  bit   done_now = 1'b0;
  bit   popped   = 1'b0;
  int   total    = 0;
  int   bad      = 0;
  int   pulses   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory-side monitor: every accepted transfer must be the oldest pending store.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (!reset && mem_valid && mem_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_xfer: transfer of %0h with nothing pending", mem_addr);
        end else begin
          chk("mem_addr", 64'(mem_addr), 64'(q[0].a));
          chk("mem_data", 64'(mem_data), 64'(q[0].d));
          void'(q.pop_front());
          popped = 1'b1;
        end
      end
    end
  end

  // One clock cycle: drive at negedge, check at +1, update model at +3 after the monitor.
  task automatic cyc(input bit rst, input bit sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                     input logic [AW-1:0] la, input bit mr, input bit fr);
    bit            full_exp, hit_exp, coal;
    logic [DW-1:0] d_exp;
    int            co_idx;
    @(negedge clock);
    reset = rst; st_valid = sv; st_addr = sa; st_data = sd;
    ld_addr = la; mem_ready = rst ? 1'b0 : mr; flush_req = fr;
    #1;
    full_exp = (q.size() == DEPTH) || in_flush;
    chk("count", 64'(count), 64'(q.size()));
    chk("count_bound", 64'(count <= CW'(DEPTH)), 64'(1));
    chk("full", 64'(full), 64'(full_exp));
    chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
    chk("flush_done", 64'(flush_done), 64'(done_now));
    hit_exp = 1'b0;
    d_exp   = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a[AW-1:2] == la[AW-1:2]) begin
        hit_exp = 1'b1;
        d_exp   = q[i].d;
        break;
      end
    end
    chk("ld_hit", 64'(ld_hit), 64'(hit_exp));
    chk("ld_data", 64'(ld_data), 64'(d_exp));
    co_idx = -1;
`ifdef WB_COALESCE_EN
    if (sv && !in_flush) begin
      for (int i = q.size() - 1; i >= 1; i--) begin
        if (q[i].a[AW-1:2] == sa[AW-1:2]) begin
          co_idx = i;
          break;
        end
      end
    end
`endif
    #2;
    pulses += int'(flush_done);
    if (rst) begin
      q.delete();
      in_flush = 1'b0;
      done_now = 1'b0;
    end else begin
      coal = (co_idx >= 0);
      if (coal) q[popped ? co_idx - 1 : co_idx].d = sd;
      if (sv && !full_exp && !coal) q.push_back('{a: sa, d: sd});
      if (done_now) done_now = 1'b0;
      else if (in_flush) begin
        if (q.size() == 0) begin
          in_flush = 1'b0;
          done_now = 1'b1;
        end
      end else if (fr) in_flush = 1'b1;
    end
    popped = 1'b0;
  endtask

  task automatic idle(input bit mr, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0, mr, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] ra, rl;
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    idle(1'b0, 1);
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_mem_valid", 64'(mem_valid), 64'(0));

    // Fill to DEPTH, reject a fifth store, then drain in order.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, AW'(32'h10 + 4 * i), DW'(i + 1), AW'(32'h10), 1'b0, 1'b0);
    cyc(1'b0, 1'b1, AW'(32'h20), DW'(32'h99), AW'(32'h20), 1'b0, 1'b0);
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_count", 64'(count), 64'(4));
    chk("fifth_ignored", 64'(ld_hit), 64'(0));
    idle(1'b1, 4);
    idle(1'b0, 1);
    chk("drain_count", 64'(count), 64'(0));

    // Same word stored twice: youngest data forwarded, byte offset ignored.
    cyc(1'b0, 1'b1, AW'(32'h40), DW'(32'hAAAA), '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, AW'(32'h40), DW'(32'hBBBB), '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, AW'(32'h42), 1'b0, 1'b0);
    chk("fwd_hit", 64'(ld_hit), 64'(1));
    chk("fwd_data", 64'(ld_data), 64'(32'hBBBB));
    cyc(1'b0, 1'b0, '0, '0, AW'(32'h44), 1'b0, 1'b0);
    chk("miss_hit", 64'(ld_hit), 64'(0));
    chk("miss_data", 64'(ld_data), 64'(0));
    idle(1'b1, 3);

    // Simultaneous enqueue/dequeue at count=2 across several pointer wraps.
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, AW'(32'h80 + 4 * i), DW'(32'h100 + i), '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, AW'(32'h90 + 4 * i), DW'(32'h200 + i), AW'(32'h90 + 4 * i), 1'b1, 1'b0);
      chk("conc_count", 64'(count), 64'(2));
    end
    idle(1'b1, 3);

    // Flush with three pending; stores during FLUSH are dropped.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, AW'(32'hC0 + 4 * i), DW'(32'h300 + i), '0, 1'b0, 1'b0);
    pulses = 0;
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, AW'(32'hF0), DW'(1), AW'(32'hF0), 1'b1, 1'b0);
    chk("flush_full", 64'(full), 64'(1));
    cyc(1'b0, 1'b1, AW'(32'hF4), DW'(2), AW'(32'hF4), 1'b0, 1'b0);
    cyc(1'b0, 1'b1, AW'(32'hF8), DW'(3), AW'(32'hF8), 1'b1, 1'b0);
    cyc(1'b0, 1'b1, AW'(32'hFC), DW'(4), AW'(32'hFC), 1'b1, 1'b0);
    idle(1'b0, 3);
    chk("flush_pulses", 64'(pulses), 64'(1));
    chk("flush_empty", 64'(count), 64'(0));

    // Reset with entries in flight.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, AW'(32'h100 + 4 * i), DW'(32'h400 + i), '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, AW'(32'h100), 1'b0, 1'b0);
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_mem_valid", 64'(mem_valid), 64'(0));
    chk("mid_rst_ld_hit", 64'(ld_hit), 64'(0));
    chk("mid_rst_full", 64'(full), 64'(0));

`ifdef WB_COALESCE_EN
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, AW'(4 * i), DW'(32'h10 + i), '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, AW'(32'h4), DW'(32'h55), '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, AW'(32'h0), DW'(32'h66), AW'(32'h4), 1'b0, 1'b0);
    chk("coal_data", 64'(ld_data), 64'(32'h55));
    idle(1'b0, 1);
    chk("coal_head_alloc", 64'(count), 64'(4));
    idle(1'b1, 5);
`endif

    // Randomised traffic over a small address pool so loads and stores collide.
    for (int n = 0; n < 3000; n++) begin
      ra = AW'($urandom_range(0, 11)) * 4 + AW'($urandom_range(0, 3));
      rl = AW'($urandom_range(0, 11)) * 4 + AW'($urandom_range(0, 3));
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 6), ra, DW'($urandom),
          rl, ($urandom_range(0, 1) == 1), ($urandom_range(0, 39) == 0));
    end
    idle(1'b1, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
